// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - memory access stage with req/ack data port and MEM/WB pipeline register
package mem_stage_pkg;
  typedef struct packed {
    logic       reg_write;
    logic       mem_to_reg;
    logic [1:0] wb_sel;
  } wb_control_t;
endpackage

module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int MAX_WAIT = 255,
  parameter int CNT_W    = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [31:0] alu_result_in,
  input  logic [31:0] store_data,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  mem_funct3,
  input  logic [31:0] pc_offset_in,
  input  logic [31:0] immediate_in,
  input  logic [31:0] pc_incr_in,
  input  wb_control_t wb_ctrl_in,
  input  logic [4:0]  rd_addr_in,
  output logic        stall_out,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_wstrb,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        wb_valid,
  output logic [31:0] alu_result_out,
  output logic [31:0] data_out,
  output logic [31:0] pc_offset_out,
  output logic [31:0] immediate_out,
  output logic [31:0] pc_incr_out,
  output wb_control_t wb_ctrl_out,
  output logic [4:0]  rd_addr_out,
  output logic        misalign_err,
  output logic        bus_err
);

  typedef enum logic { S_IDLE, S_WAIT } state_t;

  // The timeout fires in the WAIT cycle whose count equals MAX_WAIT-1, so the
  // request is held for exactly MAX_WAIT WAIT cycles before being abandoned.
  localparam bit              TIMEOUT_EN = (MAX_WAIT > 0);
  localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'((MAX_WAIT > 0) ? MAX_WAIT - 1 : 0);

  state_t           state;
  logic [CNT_W-1:0] wait_cnt;

  // Access parameters captured when the request cannot complete in IDLE
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;
  logic [3:0]  lat_wstrb;
  logic        lat_we;
  logic [2:0]  lat_funct3;
  logic [1:0]  lat_lane;

  logic        mem_op;
  logic        misaligned;
  logic        aligned_op;
  logic        in_wait;
  logic        timeout;
  logic        access_done;
  logic        err_mis;
  logic        err_any;
  logic [1:0]  lane;
  logic [31:0] req_wdata;
  logic [3:0]  req_wstrb;
  logic [2:0]  sel_f3;
  logic [1:0]  sel_lane;
  logic        sel_store;
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;
  logic [31:0] load_data;

  assign lane       = alu_result_in[1:0];
  assign mem_op     = in_valid & (mem_read | mem_write);
  assign aligned_op = mem_op & ~misaligned;
  assign in_wait    = (state == S_WAIT);

  // Alignment rules: halfwords need addr[0]=0, words need addr[1:0]=0
  always_comb begin
    misaligned = 1'b0;
    if (mem_funct3[1:0] == 2'b01 && lane[0])
      misaligned = 1'b1;
    if (mem_funct3[1] && lane != 2'b00)
      misaligned = 1'b1;
  end

  // Store lane steering: replicate the datum to every lane, enable only its bytes
  always_comb begin
    req_wdata = store_data;
    req_wstrb = 4'b1111;
    case (mem_funct3[1:0])
      2'b00: begin
        req_wdata = {4{store_data[7:0]}};
        req_wstrb = 4'b0001 << lane;
      end
      2'b01: begin
        req_wdata = {2{store_data[15:0]}};
        req_wstrb = 4'b0011 << {lane[1], 1'b0};
      end
      default: begin
        req_wdata = store_data;
        req_wstrb = 4'b1111;
      end
    endcase
    if (!mem_write) begin
      req_wdata = 32'h0;
      req_wstrb = 4'b0000;
    end
  end

  assign timeout     = in_wait & TIMEOUT_EN & ~dmem_ack & (wait_cnt == LAST_CNT);
  assign access_done = in_wait ? (dmem_ack | timeout) : (~aligned_op | dmem_ack);
  assign err_mis     = ~in_wait & mem_op & misaligned;
  assign err_any     = err_mis | timeout;

  // Reset gates the combinational outputs so a reset mid-access drops req at once
  assign stall_out  = rst_n & ~access_done;
  assign dmem_req   = rst_n & (in_wait | aligned_op);
  assign dmem_we    = in_wait ? lat_we    : mem_write;
  assign dmem_addr  = in_wait ? lat_addr  : {alu_result_in[31:2], 2'b00};
  assign dmem_wdata = in_wait ? lat_wdata : req_wdata;
  assign dmem_wstrb = in_wait ? lat_wstrb : req_wstrb;

  assign sel_f3    = in_wait ? lat_funct3 : mem_funct3;
  assign sel_lane  = in_wait ? lat_lane   : lane;
  assign sel_store = in_wait ? lat_we     : mem_write;

  // Load alignment and sign/zero extension of the returned word
  always_comb begin
    sel_byte  = dmem_rdata[{sel_lane, 3'b000} +: 8];
    sel_half  = sel_lane[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    load_data = dmem_rdata;
    case (sel_f3)
      3'b000:  load_data = {{24{sel_byte[7]}}, sel_byte};
      3'b100:  load_data = {24'h0, sel_byte};
      3'b001:  load_data = {{16{sel_half[15]}}, sel_half};
      3'b101:  load_data = {16'h0, sel_half};
      default: load_data = dmem_rdata;
    endcase
  end

  // Access FSM: wait for ack or timeout, holding the latched request stable
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      wait_cnt   <= '0;
      lat_addr   <= 32'h0;
      lat_wdata  <= 32'h0;
      lat_wstrb  <= 4'b0000;
      lat_we     <= 1'b0;
      lat_funct3 <= 3'b000;
      lat_lane   <= 2'b00;
    end else begin
      case (state)
        S_IDLE: begin
          if (aligned_op && !dmem_ack) begin
            state      <= S_WAIT;
            wait_cnt   <= '0;
            lat_addr   <= {alu_result_in[31:2], 2'b00};
            lat_wdata  <= req_wdata;
            lat_wstrb  <= req_wstrb;
            lat_we     <= mem_write;
            lat_funct3 <= mem_funct3;
            lat_lane   <= lane;
          end
        end
        S_WAIT: begin
          if (dmem_ack || timeout) begin
            state    <= S_IDLE;
            wait_cnt <= '0;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // MEM/WB register: bubble while stalled, otherwise capture the completed instruction
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid       <= 1'b0;
      alu_result_out <= 32'h0;
      data_out       <= 32'h0;
      pc_offset_out  <= 32'h0;
      immediate_out  <= 32'h0;
      pc_incr_out    <= 32'h0;
      wb_ctrl_out    <= '0;
      rd_addr_out    <= 5'd0;
      misalign_err   <= 1'b0;
      bus_err        <= 1'b0;
    end else if (stall_out) begin
      wb_valid     <= 1'b0;
      wb_ctrl_out  <= '0;
      misalign_err <= 1'b0;
      bus_err      <= 1'b0;
    end else begin
      wb_valid       <= in_valid;
      alu_result_out <= alu_result_in;
      pc_offset_out  <= pc_offset_in;
      immediate_out  <= immediate_in;
      pc_incr_out    <= pc_incr_in;
      rd_addr_out    <= rd_addr_in;
      wb_ctrl_out    <= (in_valid && !err_any) ? wb_ctrl_in : '0;
      data_out       <= (mem_op && !sel_store && !err_any) ? load_data : 32'h0;
      misalign_err   <= err_mis;
      bus_err        <= timeout;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - self-checking bench for mem_stage with a randomized reference model
module tb_mem_stage;
  import mem_stage_pkg::*;

  localparam int MAXW = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] alu_result_in = '0;
  logic [31:0] store_data = '0;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic [2:0]  mem_funct3 = '0;
  logic [31:0] pc_offset_in = '0;
  logic [31:0] immediate_in = '0;
  logic [31:0] pc_incr_in = '0;
  wb_control_t wb_ctrl_in = '0;
  logic [4:0]  rd_addr_in = '0;
  logic        stall_out;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_wstrb;
  logic        dmem_ack = 1'b0;
  logic [31:0] dmem_rdata = '0;
  logic        wb_valid;
  logic [31:0] alu_result_out;
  logic [31:0] data_out;
  logic [31:0] pc_offset_out;
  logic [31:0] immediate_out;
  logic [31:0] pc_incr_out;
  wb_control_t wb_ctrl_out;
  logic [4:0]  rd_addr_out;
  logic        misalign_err;
  logic        bus_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_stage #(.MAX_WAIT(MAXW), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .alu_result_in(alu_result_in),
    .store_data(store_data), .mem_read(mem_read), .mem_write(mem_write),
    .mem_funct3(mem_funct3), .pc_offset_in(pc_offset_in), .immediate_in(immediate_in),
    .pc_incr_in(pc_incr_in), .wb_ctrl_in(wb_ctrl_in), .rd_addr_in(rd_addr_in),
    .stall_out(stall_out), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb), .dmem_ack(dmem_ack),
    .dmem_rdata(dmem_rdata), .wb_valid(wb_valid), .alu_result_out(alu_result_out),
    .data_out(data_out), .pc_offset_out(pc_offset_out), .immediate_out(immediate_out),
    .pc_incr_out(pc_incr_out), .wb_ctrl_out(wb_ctrl_out), .rd_addr_out(rd_addr_out),
    .misalign_err(misalign_err), .bus_err(bus_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr,
                                             input logic [31:0] word);
    int unsigned b;
    int unsigned h;
    b = (word >> (8 * (addr % 4))) & 32'hFF;
    h = (word >> (16 * ((addr / 2) % 2))) & 32'hFFFF;
    case (f3)
      3'd0:    return (b >= 128) ? b + 32'hFFFF_FF00 : b;
      3'd4:    return b;
      3'd1:    return (h >= 32768) ? h + 32'hFFFF_0000 : h;
      3'd5:    return h;
      default: return word;
    endcase
  endfunction

  // One instruction: n_wait = cycles the memory takes before acking (ack in cycle n_wait)
  task automatic run_op(input string name, input logic v, input logic rd, input logic wr,
                        input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] sdata,
                        input logic [31:0] rdata, input int n_wait, input logic [4:0] rd_a,
                        input logic [3:0] ctrl_bits);
    logic        mem, mis, berr, err, go;
    int          done;
    int unsigned lane;
    logic [31:0] e_wdata, e_data, pco, imm, pci;
    logic [3:0]  e_wstrb, e_ctrl;
    mem  = v & (rd | wr);
    mis  = mem & ((((f3 % 4) == 1) && (addr % 2 == 1)) || (f3[1] && (addr % 4 != 0)));
    go   = mem & !mis;
    berr = go & (n_wait > MAXW);
    err  = mis | berr;
    done = go ? ((n_wait < MAXW) ? n_wait : MAXW) : 0;
    lane = addr % 4;
    if (f3 % 4 == 0) begin
      e_wstrb = 4'(1 << lane);
      e_wdata = (sdata & 32'hFF) * 32'h0101_0101;
    end else if (f3 % 4 == 1) begin
      e_wstrb = 4'(3 << (lane & 2));
      e_wdata = (sdata & 32'hFFFF) * 32'h0001_0001;
    end else begin
      e_wstrb = 4'hF;
      e_wdata = sdata;
    end
    e_data = (mem && !wr && !err) ? model_load(f3, addr, rdata) : 32'h0;
    e_ctrl = (v && !err) ? ctrl_bits : 4'h0;
    pco = $urandom;
    imm = $urandom;
    pci = $urandom;
    in_valid = v; mem_read = rd; mem_write = wr; mem_funct3 = f3;
    alu_result_in = addr; store_data = sdata; rd_addr_in = rd_a;
    wb_ctrl_in = wb_control_t'(ctrl_bits);
    pc_offset_in = pco; immediate_in = imm; pc_incr_in = pci;
    for (int c = 0; c <= done; c++) begin
      dmem_ack   = go && (c == n_wait);
      dmem_rdata = dmem_ack ? rdata : $urandom;
      @(negedge clk);
      check({name, ".req"}, dmem_req, go);
      check({name, ".stall"}, stall_out, c < done);
      if (go) begin
        check({name, ".addr"}, dmem_addr, addr - lane);
        check({name, ".we"}, dmem_we, wr);
        check({name, ".wstrb"}, dmem_wstrb, wr ? e_wstrb : 4'h0);
        if (wr) check({name, ".wdata"}, dmem_wdata, e_wdata);
      end
      if (c > 0) begin
        check({name, ".bubble_valid"}, wb_valid, 1'b0);
        check({name, ".bubble_ctrl"}, {28'h0, wb_ctrl_out}, 32'h0);
      end
      @(posedge clk);
      #1;
    end
    dmem_ack = 1'b0;
    check({name, ".wb_valid"}, wb_valid, v);
    check({name, ".misalign"}, misalign_err, mis);
    check({name, ".bus_err"}, bus_err, berr);
    check({name, ".wb_ctrl"}, {28'h0, wb_ctrl_out}, {28'h0, e_ctrl});
    check({name, ".data"}, data_out, e_data);
    if (v && !err) begin
      check({name, ".alu"}, alu_result_out, addr);
      check({name, ".rd"}, rd_addr_out, rd_a);
      check({name, ".pc_off"}, pc_offset_out, pco);
      check({name, ".imm"}, immediate_out, imm);
      check({name, ".pc_incr"}, pc_incr_out, pci);
    end
    in_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    #12;
    check("rst.wb_valid", wb_valid, 1'b0);
    check("rst.stall", stall_out, 1'b0);
    check("rst.req", dmem_req, 1'b0);
    check("rst.alu", alu_result_out, 32'h0);
    check("rst.ctrl", {28'h0, wb_ctrl_out}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    run_op("alu", 1, 0, 0, 3'd0, 32'h1234, 32'h0, 32'h0, 0, 5'd5, 4'b1000);
    run_op("lb", 1, 1, 0, 3'd0, 32'h103, 32'h0, 32'h80FF_0000, 0, 5'd6, 4'b1100);
    check("lb.const", data_out, 32'hFFFF_FF80);
    run_op("lbu", 1, 1, 0, 3'd4, 32'h103, 32'h0, 32'h80FF_0000, 0, 5'd6, 4'b1100);
    check("lbu.const", data_out, 32'h0000_0080);
    run_op("sh", 1, 0, 1, 3'd1, 32'h202, 32'hABCD, 32'h0, 3, 5'd0, 4'b0000);
    run_op("lw_mis", 1, 1, 0, 3'd2, 32'h101, 32'h0, 32'h0, 0, 5'd7, 4'b1100);
    run_op("lw_tmo", 1, 1, 0, 3'd2, 32'h400, 32'h0, 32'h1111_2222, 9, 5'd8, 4'b1100);
    run_op("lw_ack4", 1, 1, 0, 3'd2, 32'h404, 32'h0, 32'hCAFE_F00D, 4, 5'd9, 4'b1100);
    run_op("bubble", 0, 1, 0, 3'd2, 32'h500, 32'h0, 32'h0, 0, 5'd1, 4'b1000);

    for (int i = 0; i < 80; i++) begin
      run_op("rnd", $urandom_range(0, 7) != 0, 1'($urandom), 1'($urandom), 3'($urandom),
             $urandom, $urandom, $urandom, int'($urandom_range(0, 6)), 5'($urandom),
             4'($urandom));
    end

    // Reset in the middle of an outstanding load, then a stale ack after release
    in_valid = 1'b1; mem_read = 1'b1; mem_write = 1'b0; mem_funct3 = 3'd2;
    alu_result_in = 32'h0000_0800; wb_ctrl_in = wb_control_t'(4'b1100); rd_addr_in = 5'd3;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    check("rw.req_before", dmem_req, 1'b1);
    check("rw.stall_before", stall_out, 1'b1);
    rst_n = 1'b0;
    #1;
    check("rw.req", dmem_req, 1'b0);
    check("rw.stall", stall_out, 1'b0);
    check("rw.wb_valid", wb_valid, 1'b0);
    check("rw.alu", alu_result_out, 32'h0);
    check("rw.data", data_out, 32'h0);
    check("rw.rd", rd_addr_out, 5'd0);
    in_valid = 1'b0; mem_read = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    dmem_ack = 1'b1;
    dmem_rdata = 32'hDEAD_BEEF;
    @(posedge clk);
    #1;
    dmem_ack = 1'b0;
    check("rw.late_ack_valid", wb_valid, 1'b0);
    check("rw.late_ack_req", dmem_req, 1'b0);
    check("rw.late_ack_stall", stall_out, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
